psmac_accum: RTL and testbench

PSMAC_ACCUM -- requirements
Module: psmac_accum

---
 rtl/psmac_accum.sv | 166 ++++++++++++++++
 tb/tb_psmac_accum.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psmac_accum.sv
// rtl/psmac_accum.sv - precision-scalable multi-lane MAC accumulator with two-stage pipeline
// Optional macro PSMAC_SAT_EN: saturating accumulator with sticky overflow flag.
module psmac_accum #(
    parameter int LANES = 4,
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 sx,
    input  logic                 sy,
    input  logic [8*LANES-1:0]   ip,
    input  logic [8*LANES-1:0]   wt,
    input  logic                 in_first,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_W-1:0]     out_data,
    output logic [7:0]           out_beats,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // 18 bits holds any lane sum: 255*255 at most, -128*255 at least.
    localparam int LW = 18;
    localparam int WW = ACC_W + 8;

    function automatic logic [LW-1:0] lane_sum(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [1:0] m,
        input logic       sa,
        input logic       sb
    );
        logic [LW-1:0] s;
        logic [LW-1:0] fa;
        logic [LW-1:0] fb;
        s = '0;
        case (m)
            2'b00: begin
                for (int k = 0; k < 4; k++) begin
                    fa = {{(LW-2){sa & a[2*k+1]}}, a[2*k +: 2]};
                    fb = {{(LW-2){sb & b[2*k+1]}}, b[2*k +: 2]};
                    s  = s + fa * fb;
                end
            end
            2'b01: begin
                for (int k = 0; k < 2; k++) begin
                    fa = {{(LW-4){sa & a[4*k+3]}}, a[4*k +: 4]};
                    fb = {{(LW-4){sb & b[4*k+3]}}, b[4*k +: 4]};
                    s  = s + fa * fb;
                end
            end
            default: begin
                fa = {{(LW-8){sa & a[7]}}, a};
                fb = {{(LW-8){sb & b[7]}}, b};
                s  = fa * fb;
            end
        endcase
        return s;
    endfunction

    logic              stall;
    logic [LW-1:0]     lane_c  [LANES];
    logic [LW-1:0]     s1_lane [LANES];
    logic              s1_valid;
    logic              s1_first;
    logic              s1_last;

    logic [ACC_W-1:0]  acc;
    logic [7:0]        cnt;
    logic              ovf;
    logic              open;

    logic              first_eff;
    logic [WW-1:0]     beat;
    logic [WW-1:0]     sum;
    logic [ACC_W-1:0]  acc_nx;
    logic [7:0]        cnt_nx;
    logic              clip;
    logic              ovf_nx;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_c[i] = lane_sum(ip[8*i +: 8], wt[8*i +: 8], mode, sx, sy);
        end
    end

    always_comb begin
        beat = '0;
        for (int i = 0; i < LANES; i++) begin
            beat = beat + {{(WW-LW){s1_lane[i][LW-1]}}, s1_lane[i]};
        end
    end

    // A beat with no open accumulation starts a new one even without in_first.
    assign first_eff = s1_first | ~open;
    assign sum = (first_eff ? '0 : {{(WW-ACC_W){acc[ACC_W-1]}}, acc}) + beat;

`ifdef PSMAC_SAT_EN
    logic [WW-ACC_W:0] sum_hi;
    logic              fits;
    assign sum_hi = sum[WW-1:ACC_W-1];
    assign fits   = (sum_hi == '0) | (sum_hi == '1);
    assign clip   = ~fits;
    assign acc_nx = fits ? sum[ACC_W-1:0]
                  : (sum[WW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[WW-1:ACC_W];
    assign clip   = 1'b0;
    assign acc_nx = sum[ACC_W-1:0];
`endif

    assign ovf_nx = (~first_eff & ovf) | clip;
    assign cnt_nx = first_eff ? 8'd1 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_lane[i] <= '0;
            end
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            open      <= 1'b0;
            out_data  <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_lane  <= lane_c;
            end
            // Not stalled means any held result is being taken this cycle.
            out_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    out_data  <= acc_nx;
                    out_beats <= cnt_nx;
                    out_ovf   <= ovf_nx;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    open      <= 1'b0;
                end else begin
                    acc  <= acc_nx;
                    cnt  <= cnt_nx;
                    ovf  <= ovf_nx;
                    open <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psmac_accum.sv
// tb/tb_psmac_accum.sv - randomized and directed bench for psmac_accum against a beat-level model
module tb_psmac_accum;

    localparam int LANES = 4;
    localparam int ACC_W = 24;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          mode = '0;
    logic                sx = 1'b0;
    logic                sy = 1'b0;
    logic [8*LANES-1:0]  ip = '0;
    logic [8*LANES-1:0]  wt = '0;
    logic                in_first = 1'b0;
    logic                in_last = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ACC_W-1:0]    out_data;
    logic [7:0]          out_beats;
    logic                out_ovf;
    logic                out_valid;
    logic                out_ready = 1'b1;

    psmac_accum #(.LANES(LANES), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sx(sx), .sy(sy), .ip(ip), .wt(wt),
        .in_first(in_first), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_beats(out_beats), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        int     beats;
        bit     ovf;
    } res_t;

    res_t   exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     n_results = 0;
    int     cyc = 0;
    int     last_acc_cyc = 0;
    int     last_pop_cyc = 0;
    longint last_data = 0;
    int     last_beats = 0;
    bit     last_ovf = 0;
    bit     rdy_rand = 0;
    bit     rdy_force = 1;

    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 0;
    bit     m_open = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint field(input logic [31:0] v, input int sh, input int w, input bit sgn);
        longint x;
        x = longint'((v >> sh) & ((32'd1 << w) - 1));
        if (sgn && x >= (64'sd1 <<< (w - 1))) x = x - (64'sd1 <<< w);
        return x;
    endfunction

    function automatic longint model_beat(input int m, input bit sa, input bit sb,
                                          input logic [31:0] a, input logic [31:0] b);
        int     w;
        longint s;
        w = (m == 0) ? 2 : ((m == 1) ? 4 : 8);
        s = 0;
        for (int ln = 0; ln < LANES; ln++) begin
            for (int k = 0; k < 8 / w; k++) begin
                s += field(a, ln * 8 + k * w, w, sa) * field(b, ln * 8 + k * w, w, sb);
            end
        end
        return s;
    endfunction

    task automatic model_accept();
        longint b;
        longint lim;
        res_t   r;
        b   = model_beat(int'(mode), sx, sy, ip, wt);
        lim = 64'sd1 <<< (ACC_W - 1);
        if (in_first || !m_open) begin
            m_acc = b;
            m_cnt = 1;
            m_ovf = 0;
        end else begin
            m_acc = m_acc + b;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
`ifdef PSMAC_SAT_EN
        if (m_acc > lim - 1) begin m_acc = lim - 1; m_ovf = 1; end
        if (m_acc < -lim)    begin m_acc = -lim;    m_ovf = 1; end
`else
        m_acc = m_acc & ((64'sd1 <<< ACC_W) - 1);
        if (m_acc >= lim) m_acc = m_acc - (64'sd1 <<< ACC_W);
`endif
        if (in_last) begin
            r.data  = m_acc;
            r.beats = m_cnt;
            r.ovf   = m_ovf;
            exp_q.push_back(r);
            m_open = 0;
            m_acc  = 0;
            last_acc_cyc = cyc;
        end else begin
            m_open = 1;
        end
    endtask

    // Compare process: samples one time unit before every rising edge.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                exp_q.delete();
                m_open = 0;
                m_acc  = 0;
                m_cnt  = 0;
                m_ovf  = 0;
            end else begin
                chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("out_data",  longint'($signed(out_data)), r.data);
                        chk("out_beats", longint'(out_beats), longint'(r.beats));
                        chk("out_ovf",   longint'(out_ovf), longint'(r.ovf));
                    end
                    last_data    = longint'($signed(out_data));
                    last_beats   = int'(out_beats);
                    last_ovf     = out_ovf;
                    last_pop_cyc = cyc;
                    n_results++;
                end
                if (in_valid && in_ready) model_accept();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            out_ready = rdy_rand ? ($urandom_range(2) != 0) : rdy_force;
        end
    end

    task automatic send(input logic [1:0] m, input bit a_s, input bit b_s,
                        input logic [31:0] a, input logic [31:0] b, input bit f, input bit l);
        bit done;
        @(negedge clk);
        mode = m; sx = a_s; sy = b_s; ip = a; wt = b;
        in_first = f; in_last = l; in_valid = 1'b1;
        done = 0;
        for (int t = 0; t < 200; t++) begin
            #4;
            if (in_ready) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_result(input int n0);
        for (int t = 0; t < 100; t++) begin
            if (n_results > n0) break;
            @(negedge clk);
            in_valid = 1'b0;
        end
        if (n_results <= n0) chk("result_timeout", 0, 1);
    endtask

    initial begin
        int n0;
        #2;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data",  longint'(out_data), 0);
        chk("rst_out_beats", longint'(out_beats), 0);
        chk("rst_out_ovf",   longint'(out_ovf), 0);
        chk("rst_in_ready",  longint'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // 8b signed: -1 * 2 per lane, with latency check
        n0 = n_results;
        send(2'b10, 1, 1, 32'hFFFFFFFF, 32'h02020202, 1, 1);
        wait_result(n0);
        chk("d034_data", last_data, -8);
        chk("d034_beats", longint'(last_beats), 1);
        chk("d034_latency", longint'(last_pop_cyc - last_acc_cyc), 2);

        n0 = n_results;
        send(2'b01, 0, 0, 32'hFFFFFFFF, 32'h11111111, 1, 1);
        wait_result(n0);
        chk("d035_data", last_data, 120);

        n0 = n_results;
        send(2'b00, 1, 1, 32'hFFFFFFFF, 32'h55555555, 1, 1);
        wait_result(n0);
        chk("d036_data", last_data, -16);

        n0 = n_results;
        send(2'b10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        send(2'b10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        send(2'b10, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
        wait_result(n0);
        chk("d037_data", last_data, 780300);
        chk("d037_beats", longint'(last_beats), 3);

        n0 = n_results;
        for (int i = 0; i < 128; i++) begin
            send(2'b10, 1, 1, 32'h80808080, 32'h80808080, i == 0, i == 127);
        end
        wait_result(n0);
`ifdef PSMAC_SAT_EN
        chk("d039_data", last_data, 8388607);
        chk("d039_ovf", longint'(last_ovf), 1);
`else
        chk("d039_data", last_data, -8388608);
        chk("d039_ovf", longint'(last_ovf), 0);
`endif

        // Beat counter saturation
        n0 = n_results;
        for (int i = 0; i < 300; i++) begin
            send(2'b10, 0, 0, 32'h0, 32'h0, i == 0, i == 299);
        end
        wait_result(n0);
        chk("beats_sat", longint'(last_beats), 255);

        // Back-pressure: results held, stream continues, nothing lost
        idle(3);
        rdy_force = 0;
        send(2'b10, 0, 0, 32'h01020304, 32'h01010101, 1, 1);
        send(2'b01, 1, 0, 32'h9A3C77E1, 32'h12345678, 1, 1);
        fork
            send(2'b00, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 1, 1);
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("stall_in_ready", longint'(in_ready), 0);
                rdy_force = 1;
            end
        join
        idle(8);

        // Reset mid-accumulation with a held result
        rdy_force = 0;
        send(2'b10, 0, 0, 32'h05050505, 32'h05050505, 1, 0);
        send(2'b10, 0, 0, 32'h05050505, 32'h05050505, 0, 1);
        send(2'b10, 0, 0, 32'h07070707, 32'h07070707, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("held_before_rst", longint'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_out_data",  longint'(out_data), 0);
        chk("mid_rst_in_ready",  longint'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        rdy_force = 1;
        n0 = n_results;
        send(2'b10, 0, 0, 32'h01010101, 32'h03030303, 0, 1);
        wait_result(n0);
        chk("after_rst_data", last_data, 12);
        chk("after_rst_beats", longint'(last_beats), 1);

        // Randomized traffic with random back-pressure
        rdy_rand = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(4) == 0) begin
                idle(1);
            end else begin
                send(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                     $urandom, $urandom, $urandom_range(3) == 0, $urandom_range(3) == 0);
            end
        end
        send(2'b10, 1, 0, $urandom, $urandom, 0, 1);
        idle(1);
        rdy_rand = 0;
        rdy_force = 1;
        idle(12);
        chk("queue_drained", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
